// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART transceiver.
//   uart_state_t : FSM state encoding shared by the RX and TX machines.
//   cnt_w()      : width of the per-bit cycle counter for a given bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Counter must hold 0 .. clks_per_bit-1; never narrower than one bit.
    function automatic int cnt_w(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter for one UART direction.
//   clk, rst_n : system clock, synchronous active-low reset
//   clear      : force the counter to 0 on the next edge (re-phases the bit grid)
//   tick       : high while the counter sits at CLKS_PER_BIT-1 (last cycle of a bit)
//   half       : high while the counter sits at CLKS_PER_BIT/2-1 (mid-bit)
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic half
);

    localparam int            CW       = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by clear: the RX FSM derives clear from half, gating would loop.
    assign tick = (cnt_q == LAST_CNT);
    assign half = (cnt_q == HALF_CNT);

endmodule

// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART with valid/ready on both sides.
//   clk, rst_n        : system clock, synchronous active-low reset
//   rx_pin / tx_pin   : serial lines, idle high
//   tx_data/valid/ready : byte to transmit, accepted on tx_valid & tx_ready
//   rx_data/valid/ready : received byte, held until rx_valid & rx_ready
//   rx_frame_err      : 1-cycle pulse, stop bit sampled low (byte dropped)
//   rx_parity_err     : 1-cycle pulse, parity mismatch (0 unless UART_PARITY_EN)
//   rx_overrun        : 1-cycle pulse, good frame arrived while rx_data unconsumed
// Build option: define UART_PARITY_EN to add a parity bit (sense = PARITY_ODD).
//
// Both FSMs use the same states:
//   state  | meaning
//   IDLE   | line idle; TX ready for a byte / RX watching for a falling edge
//   START  | start bit (RX confirms it at mid-bit, rejecting glitches)
//   DATA   | DATA_BITS payload bits, LSB first
//   PARITY | parity bit (only reachable with UART_PARITY_EN)
//   STOP   | stop bit(s); RX checks the first one at mid-bit
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic                 tx_pin,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int           BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic        PAR_ODD    = 1'(PARITY_ODD);
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam uart_state_t AFTER_DATA = STOP;
    logic parity_odd_unused;
    assign parity_odd_unused = 1'(PARITY_ODD);
`endif

    // ------------------------------------------------------------------
    // RX input synchroniser (preset high so reset looks like an idle line)
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_pin;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    uart_state_t          rx_state_q, rx_state_d;
    logic [BW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_overrun_q, rx_overrun_d;
    logic                 rx_clear;
    logic                 rx_tick;
    logic                 rx_half;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad_q, rx_par_bad_d;
    logic                 rx_parity_err_q, rx_parity_err_d;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rx_clear),
        .tick  (rx_tick),
        .half  (rx_half)
    );

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_idx_d       = rx_idx_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q & ~rx_ready;
        rx_frame_err_d = 1'b0;
        rx_overrun_d   = 1'b0;
        rx_clear       = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_d    = rx_par_bad_q;
        rx_parity_err_d = 1'b0;
`endif

        case (rx_state_q)
            IDLE: begin
                rx_clear = 1'b1;
                rx_idx_d = '0;
`ifdef UART_PARITY_EN
                rx_par_bad_d = 1'b0;
`endif
                if (!rx_s_q) begin
                    rx_state_d = START;
                end
            end
            START: begin
                // Restart the bit grid at mid start-bit so later ticks land mid-bit.
                if (rx_half) begin
                    rx_clear   = 1'b1;
                    rx_state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_idx_d   = rx_idx_q + BW'(1);
                    if (rx_idx_q == LAST_BIT) begin
                        rx_state_d = AFTER_DATA;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (rx_tick) begin
                    rx_par_bad_d = rx_s_q ^ (^rx_shift_q) ^ PAR_ODD;
                    rx_state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_tick) begin
                    rx_state_d = IDLE;
`ifdef UART_PARITY_EN
                    rx_parity_err_d = rx_par_bad_q;
`endif
                    if (!rx_s_q) begin
                        rx_frame_err_d = 1'b1;
                    end else if (rx_valid_q && !rx_ready) begin
                        rx_overrun_d = 1'b1;
                    end else begin
                        // A consume on this same cycle frees the slot; load wins.
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q     <= IDLE;
            rx_idx_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_overrun_q   <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_idx_q       <= rx_idx_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_par_bad_q    <= 1'b0;
            rx_parity_err_q <= 1'b0;
        end else begin
            rx_par_bad_q    <= rx_par_bad_d;
            rx_parity_err_q <= rx_parity_err_d;
        end
    end

    assign rx_parity_err = rx_parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_overrun   = rx_overrun_q;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    uart_state_t          tx_state_q, tx_state_d;
    logic [BW-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_pin_q, tx_pin_d;
    logic                 tx_clear;
    logic                 tx_tick;
    logic                 tx_half_unused;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tx_clear),
        .tick  (tx_tick),
        .half  (tx_half_unused)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_clear   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d = tx_par_q;
`endif

        case (tx_state_q)
            IDLE: begin
                tx_clear = 1'b1;
                tx_idx_d = '0;
                // tx_ready_q gates acceptance: it is still low on the first
                // cycle after reset even though the state is already IDLE.
                if (tx_valid && tx_ready_q) begin
                    tx_shift_d = tx_data;
                    tx_state_d = START;
`ifdef UART_PARITY_EN
                    tx_par_d = (^tx_data) ^ PAR_ODD;
`endif
                end
            end
            START: begin
                if (tx_tick) begin
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_tick) begin
                    if (tx_idx_q == LAST_BIT) begin
                        tx_idx_d   = '0;
                        tx_state_d = AFTER_DATA;
                    end else begin
                        tx_idx_d   = tx_idx_q + BW'(1);
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tx_tick) begin
                    tx_state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tx_tick) begin
                    if (tx_idx_q == LAST_STOP) begin
                        tx_state_d = IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + BW'(1);
                    end
                end
            end
            default: begin
                tx_state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so the pin and ready
        // change on the same edge as the state.
        tx_ready_d = (tx_state_d == IDLE);
        tx_pin_d   = 1'b1;
        case (tx_state_d)
            START:   tx_pin_d = 1'b0;
            DATA:    tx_pin_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_pin_d = tx_par_d;
`endif
            default: tx_pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_ready_q <= 1'b0;
            tx_pin_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_ready_q <= tx_ready_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_par_q <= 1'b0;
        end else begin
            tx_par_q <= tx_par_d;
        end
    end
`endif

    assign tx_pin   = tx_pin_q;
    assign tx_ready = tx_ready_q;

endmodule
